// File: rtl/adder_seq_ctrl.sv
// Byte-serial multi-precision add/subtract sequencer.
// It processes one 8-bit slice per clock, LSB first, and uses a start/busy/done handshake.
module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_out,
  output logic                  overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;

  logic [8:0]      w_sum;
  logic            w_last;

  // r_b already holds ~op_b for subtract, so one adder serves both operations.
  assign w_sum  = {1'b0, r_a[8*r_idx +: 8]} + {1'b0, r_b[8*r_idx +: 8]} + {8'd0, r_carry};
  assign w_last = (r_idx == IW'(NBYTES - 1));

  // NOTE: state is updated only with non-blocking assignments, so every branch
  // below reads the pre-edge register values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          result[8*r_idx +: 8] <= w_sum[7:0];
          r_carry              <= w_sum[8];
          if (w_last) begin
            r_idx    <= '0;
            r_state  <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            c_out    <= w_sum[8];
            overflow <= (r_a[W-1] == r_b[W-1]) && (w_sum[7] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          done <= 1'b0;
          if (start) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl with NBYTES=4.
// It uses directed vectors, reset mid-run, back-to-back starts and a random sweep against a full-width model.
module tb_adder_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          c_out;
  logic          overflow;

  int total;
  int bad;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] res;
    logic         c;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full-width reference: returns {c_out, overflow, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] bx;
    logic [W:0]   sum;
    logic         ov;
    bx  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, s};
    ov  = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
    return {sum[W], ov, sum[W-1:0]};
  endfunction

  // Launch one operation from idle and check timing, outputs and the one-cycle done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] e_res, input logic e_c, input logic e_ov);
    int n;
    int busy_cnt;
    int both;
    logic seen;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    sub   = 1'b0;
    n = 0; busy_cnt = 0; both = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
      if (busy && done) both++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("latency", n, NBYTES);
    check("busy_cycles", busy_cnt, NBYTES);
    check("busy_and_done", both, 0);
    check("result", result, e_res);
    check("c_out", c_out, e_c);
    check("overflow", overflow, e_ov);
    @(posedge clk);
    #1;
    check("done_pulse_end", done, 1'b0);
    check("c_out_hold", c_out, e_c);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] bb_a[20];
    logic [W-1:0] bb_b[20];
    logic         bb_s[20];
    int           pulses;
    total = 0;
    bad   = 0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].c, vecs[i].ov);

    // Reset after two slices of an operation whose previous result is non-zero.
    run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    @(negedge clk);
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 0);
    check("midrst_c_out", c_out, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run_op(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 32'hDEAD_BF00, 1'b0, 1'b0);

    // Start is held high with new operands every cycle, so an accept is expected every NBYTES+1 edges.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bb_a[c] = $urandom;
      bb_b[c] = $urandom;
      bb_s[c] = 1'($urandom_range(1));
      op_a  = bb_a[c];
      op_b  = bb_b[c];
      sub   = bb_s[c];
      start = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_done", done, (c % 5) == 4);
      check("b2b_busy", busy, (c % 5) != 4);
      if ((c % 5) == 4) begin
        m = model(bb_a[c-4], bb_b[c-4], bb_s[c-4]);
        check("b2b_result", result, m[W-1:0]);
        check("b2b_c_out", c_out, m[W+1]);
        check("b2b_overflow", overflow, m[W]);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_idle", busy, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1));
      m  = model(ra, rb, rs);
      run_op(ra, rb, rs, m[W-1:0], m[W+1], m[W]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
